// File: rtl/ransac_inlier_counter.sv
// -----------------------------------------------------------------------------
// ransac_fixed / ransac_inlier_counter
//
// Purpose:
//   Scores one candidate plane against a stream of points. For every point the
//   signed residual n.p + d is accumulated exactly (8.24 fixed-point inputs,
//   full-precision 16.48 products) and the point is counted as an inlier when
//   |residual| <= threshold. A single multiplier is shared across the three
//   normal components, so each point takes five cycles:
//   WAIT_POINT -> MUL_X -> MUL_Y -> MUL_Z -> COMPARE.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   plane_valid / plane_ready   plane + threshold handshake (ready only in IDLE)
//   plane, threshold            candidate plane {normal.x, normal.y, normal.z, d}
//                               and non-negative distance tolerance
//   point_valid / point_ready   point handshake (ready only in WAIT_POINT)
//   point, point_last           point {x, y, z}; point_last marks the final point
//   result_valid / result_ready result handshake (valid only in RESULT)
//   inlier_count, point_count   saturating counts for the current plane
// -----------------------------------------------------------------------------

package ransac_fixed;
  // Signed 8.24 fixed point.
  typedef logic signed [31:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  typedef vec3_t point_t;

  typedef struct packed {
    vec3_t  normal;
    fixed_t d;
  } plane_t;
endpackage

module ransac_inlier_counter
  import ransac_fixed::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   plane_valid,
  output logic                   plane_ready,
  input  plane_t                 plane,
  input  fixed_t                 threshold,
  input  logic                   point_valid,
  output logic                   point_ready,
  input  point_t                 point,
  input  logic                   point_last,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [COUNT_WIDTH-1:0] inlier_count,
  output logic [COUNT_WIDTH-1:0] point_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_POINT,
    S_MUL_X,
    S_MUL_Y,
    S_MUL_Z,
    S_COMPARE,
    S_RESULT
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Captured transfer data.
  plane_t r_plane;
  fixed_t r_threshold;
  point_t r_point;
  logic   r_last;

  // 66 bits: three 64-bit products plus d << 24 cannot overflow.
  logic signed [65:0]     r_acc;
  logic [COUNT_WIDTH-1:0] r_inliers;
  logic [COUNT_WIDTH-1:0] r_points;

  logic               w_plane_xfer;
  logic               w_point_xfer;
  fixed_t             w_mul_a;
  fixed_t             w_mul_b;
  logic signed [63:0] w_mul_a_ext;
  logic signed [63:0] w_mul_b_ext;
  logic signed [63:0] w_prod;
  logic [65:0]        w_acc_abs;
  logic [65:0]        w_limit;
  logic               w_is_inlier;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    plane_ready  = 1'b0;
    point_ready  = 1'b0;
    result_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        plane_ready = 1'b1;
        if (plane_valid) w_next_state = S_WAIT_POINT;
      end
      S_WAIT_POINT: begin
        point_ready = 1'b1;
        if (point_valid) w_next_state = S_MUL_X;
      end
      S_MUL_X:   w_next_state = S_MUL_Y;
      S_MUL_Y:   w_next_state = S_MUL_Z;
      S_MUL_Z:   w_next_state = S_COMPARE;
      S_COMPARE: w_next_state = r_last ? S_RESULT : S_WAIT_POINT;
      S_RESULT: begin
        result_valid = 1'b1;
        if (result_ready) w_next_state = S_IDLE;
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  assign w_plane_xfer = plane_valid && plane_ready;
  assign w_point_xfer = point_valid && point_ready;

  // ---------------------------------------------------------------------------
  // Shared multiplier: operand pair selected by the current MUL state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_MUL_X: begin
        w_mul_a = r_plane.normal.x;
        w_mul_b = r_point.x;
      end
      S_MUL_Y: begin
        w_mul_a = r_plane.normal.y;
        w_mul_b = r_point.y;
      end
      S_MUL_Z: begin
        w_mul_a = r_plane.normal.z;
        w_mul_b = r_point.z;
      end
      default: begin
        w_mul_a = '0;
        w_mul_b = '0;
      end
    endcase
  end

  // Operands are sign-extended to 64 bits so the low 64 bits of the product are
  // the exact signed 32x32 result.
  assign w_mul_a_ext = {{32{w_mul_a[31]}}, w_mul_a};
  assign w_mul_b_ext = {{32{w_mul_b[31]}}, w_mul_b};
  assign w_prod      = w_mul_a_ext * w_mul_b_ext;

  // Residual and threshold share the 16.48 scale of the products. The most
  // negative accumulator value is unreachable, so negation cannot overflow.
  assign w_acc_abs   = r_acc[65] ? 66'(-r_acc) : 66'(r_acc);
  assign w_limit     = {10'b0, r_threshold, 24'b0};
  assign w_is_inlier = (w_acc_abs <= w_limit);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_plane     <= '0;
      r_threshold <= '0;
      r_point     <= '0;
      r_last      <= 1'b0;
      r_acc       <= '0;
      r_inliers   <= '0;
      r_points    <= '0;
    end else begin
      if (w_plane_xfer) begin
        r_plane     <= plane;
        r_threshold <= threshold;
        r_inliers   <= '0;
        r_points    <= '0;
      end

      if (w_point_xfer) begin
        r_point <= point;
        r_last  <= point_last;
        // Seed with d scaled up to the 16.48 product format.
        r_acc   <= {{10{r_plane.d[31]}}, r_plane.d, 24'b0};
      end

      if (r_state == S_MUL_X || r_state == S_MUL_Y || r_state == S_MUL_Z) begin
        r_acc <= r_acc + {{2{w_prod[63]}}, w_prod};
      end

      if (r_state == S_COMPARE) begin
        // Both counters stick at all-ones rather than wrapping.
        if (r_points != '1) r_points <= r_points + COUNT_WIDTH'(1);
        if (w_is_inlier && (r_inliers != '1)) r_inliers <= r_inliers + COUNT_WIDTH'(1);
      end
    end
  end

  assign inlier_count = r_inliers;
  assign point_count  = r_points;

endmodule

// File: tb/tb_ransac_inlier_counter.sv
// -----------------------------------------------------------------------------
// tb_ransac_inlier_counter
//
// Drives planes and point streams into two instances of ransac_inlier_counter
// (COUNT_WIDTH 16 and COUNT_WIDTH 2) and compares handshakes, latency and
// counts against a reference computed from the plane equation in wide integer
// arithmetic.
// -----------------------------------------------------------------------------

module tb_ransac_inlier_counter;
  import ransac_fixed::*;

  logic   clk = 1'b0;
  logic   reset;
  logic   plane_valid;
  plane_t plane;
  fixed_t threshold;
  logic   point_valid;
  point_t point;
  logic   point_last;
  logic   result_ready;

  logic        plane_ready, point_ready, result_valid;
  logic [15:0] inlier_count, point_count;
  logic        s_plane_ready, s_point_ready, s_result_valid;
  logic [1:0]  s_inlier_count, s_point_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state for the set in progress.
  plane_t cur_plane;
  fixed_t cur_thr;
  int     exp_inl;
  int     exp_pts;

  always #5 clk = ~clk;

  ransac_inlier_counter #(.COUNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .plane_valid  (plane_valid),
    .plane_ready  (plane_ready),
    .plane        (plane),
    .threshold    (threshold),
    .point_valid  (point_valid),
    .point_ready  (point_ready),
    .point        (point),
    .point_last   (point_last),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .inlier_count (inlier_count),
    .point_count  (point_count)
  );

  ransac_inlier_counter #(.COUNT_WIDTH(2)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .plane_valid  (plane_valid),
    .plane_ready  (s_plane_ready),
    .plane        (plane),
    .threshold    (threshold),
    .point_valid  (point_valid),
    .point_ready  (s_point_ready),
    .point        (point),
    .point_last   (point_last),
    .result_valid (s_result_valid),
    .result_ready (result_ready),
    .inlier_count (s_inlier_count),
    .point_count  (s_point_count)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic signed [95:0] wide(input fixed_t v);
    return {{64{v[31]}}, v};
  endfunction

  // Residual n.p + d in units of 2^-48; inlier when |residual| <= thr * 2^24.
  function automatic bit model_inlier(input plane_t pl, input fixed_t thr, input point_t p);
    logic signed [95:0] r;
    logic signed [95:0] a;
    logic signed [95:0] lim;
    r   = wide(pl.normal.x) * wide(p.x) + wide(pl.normal.y) * wide(p.y)
        + wide(pl.normal.z) * wide(p.z) + wide(pl.d) * 96'sd16777216;
    a   = (r < 0) ? -r : r;
    lim = {64'b0, thr};
    lim = lim * 96'sd16777216;
    return a <= lim;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic fixed_t rand_fixed(input int half_range);
    int v;
    v = int'($urandom_range(0, 2 * half_range - 1)) - half_range;
    return fixed_t'(v);
  endfunction

  function automatic point_t rand_point();
    point_t p;
    p.x = rand_fixed(32'h0200_0000);
    p.y = rand_fixed(32'h0200_0000);
    p.z = rand_fixed(32'h0200_0000);
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_plane(input plane_t pl, input fixed_t thr);
    bit rdy;
    int t;
    t           = 0;
    plane       = pl;
    threshold   = thr;
    plane_valid = 1'b1;
    do begin
      rdy = plane_ready;
      tick();
      t++;
    end while (!rdy && t < 100);
    plane_valid = 1'b0;
    plane       = {$urandom, $urandom, $urandom, $urandom};
    threshold   = fixed_t'($urandom);
    n_checks++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL plane_accept: plane_ready stayed 0 for %0d cycles, required 1", t);
    end
    cur_plane = pl;
    cur_thr   = thr;
    exp_inl   = 0;
    exp_pts   = 0;
  endtask

  // Offers one point after `gap` idle cycles, then checks the four busy cycles,
  // the counter update on the COMPARE edge and the state entered afterwards.
  task automatic send_point(input point_t p, input bit last, input int gap);
    bit rdy;
    int t;
    point_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      point       = rand_point();
      point_last  = 1'($urandom);
      plane_valid = 1'($urandom);
      tick();
    end
    plane_valid = 1'b0;
    point       = p;
    point_last  = last;
    point_valid = 1'b1;
    t = 0;
    do begin
      rdy = point_ready;
      tick();
      t++;
    end while (!rdy && t < 100);
    n_checks++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL point_accept: point_ready stayed 0 for %0d cycles, required 1", t);
    end else begin
      exp_pts++;
      if (model_inlier(cur_plane, cur_thr, p)) exp_inl++;
    end
    point      = rand_point();
    point_last = 1'($urandom);

    // MUL_X, MUL_Y, MUL_Z, COMPARE: nothing may be ready or valid; extra
    // valids on both input channels must be ignored.
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (point_ready !== 1'b0 || plane_ready !== 1'b0 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_cycle%0d: point_ready=%b plane_ready=%b result_valid=%b required 0 0 0",
                 k, point_ready, plane_ready, result_valid);
      end
      point_valid = 1'($urandom);
      plane_valid = 1'($urandom);
      tick();
    end
    point_valid = 1'b0;
    plane_valid = 1'b0;

    n_checks++;
    if (inlier_count !== 16'(exp_inl) || point_count !== 16'(exp_pts)) begin
      n_fail++;
      $display("FAIL counts_after_point: inlier=%0d points=%0d required %0d %0d",
               inlier_count, point_count, exp_inl, exp_pts);
    end
    n_checks++;
    if (s_inlier_count !== 2'(sat3(exp_inl)) || s_point_count !== 2'(sat3(exp_pts))) begin
      n_fail++;
      $display("FAIL sat_counts_after_point: inlier=%0d points=%0d required %0d %0d",
               s_inlier_count, s_point_count, sat3(exp_inl), sat3(exp_pts));
    end
    n_checks++;
    if (last) begin
      if (result_valid !== 1'b1 || point_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL result_latency: result_valid=%b point_ready=%b five cycles after last accept, required 1 0",
                 result_valid, point_ready);
      end
    end else begin
      if (point_ready !== 1'b1 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL point_throughput: point_ready=%b result_valid=%b five cycles after accept, required 1 0",
                 point_ready, result_valid);
      end
    end
  endtask

  // Holds result_ready low for `hold` cycles, then accepts the result.
  task automatic collect_result(input int hold);
    for (int k = 0; k <= hold; k++) begin
      n_checks++;
      if (result_valid !== 1'b1 || s_result_valid !== 1'b1 || point_ready !== 1'b0 ||
          inlier_count !== 16'(exp_inl) || point_count !== 16'(exp_pts) ||
          s_inlier_count !== 2'(sat3(exp_inl)) || s_point_count !== 2'(sat3(exp_pts))) begin
        n_fail++;
        $display("FAIL result_hold%0d: valid=%b/%b point_ready=%b counts=%0d/%0d sat=%0d/%0d required 1/1 0 %0d/%0d sat=%0d/%0d",
                 k, result_valid, s_result_valid, point_ready, inlier_count, point_count,
                 s_inlier_count, s_point_count, exp_inl, exp_pts, sat3(exp_inl), sat3(exp_pts));
      end
      if (k < hold) begin
        point_valid = 1'($urandom);
        plane_valid = 1'($urandom);
        point       = rand_point();
        tick();
      end
    end
    point_valid  = 1'b0;
    plane_valid  = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0 || plane_ready !== 1'b1 ||
        inlier_count !== 16'(exp_inl) || point_count !== 16'(exp_pts)) begin
      n_fail++;
      $display("FAIL result_xfer: result_valid=%b plane_ready=%b counts=%0d/%0d required 0 1 %0d/%0d",
               result_valid, plane_ready, inlier_count, point_count, exp_inl, exp_pts);
    end
  endtask

  task automatic random_set(input int n_points, input int max_gap, input int hold);
    plane_t pl;
    pl.normal.x = rand_fixed(32'h0100_0000);
    pl.normal.y = rand_fixed(32'h0100_0000);
    pl.normal.z = rand_fixed(32'h0100_0000);
    pl.d        = rand_fixed(32'h0200_0000);
    send_plane(pl, fixed_t'($urandom_range(0, 32'h0200_0000)));
    for (int i = 0; i < n_points; i++) begin
      send_point(rand_point(), (i == n_points - 1), int'($urandom_range(0, max_gap)));
    end
    collect_result(hold);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset        = 1'b1;
    plane_valid  = 1'b0;
    point_valid  = 1'b0;
    point_last   = 1'b0;
    result_ready = 1'b0;
    plane        = '0;
    threshold    = '0;
    point        = '0;
    tick();
    tick();
    n_checks++;
    if (plane_ready !== 1'b1 || point_ready !== 1'b0 || result_valid !== 1'b0 ||
        inlier_count !== 16'd0 || point_count !== 16'd0 ||
        s_inlier_count !== 2'd0 || s_point_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: plane_ready=%b point_ready=%b result_valid=%b counts=%0d/%0d sat=%0d/%0d required 1 0 0 0/0 0/0",
               plane_ready, point_ready, result_valid, inlier_count, point_count,
               s_inlier_count, s_point_count);
    end
    reset = 1'b0;
    tick();
  endtask

  function automatic plane_t z_plane();
    return {32'h0000_0000, 32'h0000_0000, 32'h0100_0000, 32'hFF00_0000};
  endfunction

  function automatic point_t z_point(input fixed_t z);
    return {rand_fixed(32'h7000_0000), rand_fixed(32'h7000_0000), z};
  endfunction

  task automatic test_basic();
    send_plane(z_plane(), 32'h0019_999A);
    send_point(z_point(32'h0100_0000), 1'b0, 0);
    send_point(z_point(32'h010C_CCCD), 1'b0, 1);
    send_point(z_point(32'h0200_0000), 1'b1, 0);
    collect_result(0);
  endtask

  task automatic test_boundary();
    send_plane(z_plane(), 32'h0080_0000);
    send_point(z_point(32'h0180_0000), 1'b0, 0);
    send_point(z_point(32'h0080_0000), 1'b0, 0);
    send_point(z_point(32'h0180_0001), 1'b1, 0);
    collect_result(1);
  endtask

  task automatic test_signed_normal();
    send_plane({32'hFF00_0000, 32'h0000_0000, 32'h0000_0000, 32'h0200_0000}, 32'h0000_0000);
    send_point({32'h0200_0000, rand_fixed(32'h7000_0000), rand_fixed(32'h7000_0000)}, 1'b0, 0);
    send_point({32'hFE00_0000, rand_fixed(32'h7000_0000), rand_fixed(32'h7000_0000)}, 1'b1, 2);
    collect_result(0);
  endtask

  task automatic test_saturation();
    send_plane(z_plane(), 32'h0000_1000);
    for (int i = 0; i < 5; i++) begin
      send_point(z_point(32'h0100_0000), (i == 4), 0);
    end
    collect_result(0);
  endtask

  task automatic test_back_to_back();
    random_set(6, 0, 0);
    random_set(3, 0, 0);
  endtask

  task automatic test_handshake_stress();
    random_set(5, 4, 10);
    for (int s = 0; s < 6; s++) begin
      random_set(int'($urandom_range(1, 8)), 3, int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_reset_mid();
    bit rdy;
    int t;
    send_plane(z_plane(), 32'h0019_999A);
    send_point(z_point(32'h0100_0000), 1'b0, 0);
    point       = z_point(32'h0100_0000);
    point_last  = 1'b0;
    point_valid = 1'b1;
    t = 0;
    do begin
      rdy = point_ready;
      tick();
      t++;
    end while (!rdy && t < 100);
    point_valid = 1'b0;
    n_checks++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL reset_mid_accept: point_ready stayed 0 for %0d cycles, required 1", t);
    end
    tick();          // now in MUL_Y
    reset = 1'b1;
    tick();
    n_checks++;
    if (plane_ready !== 1'b1 || point_ready !== 1'b0 || result_valid !== 1'b0 ||
        inlier_count !== 16'd0 || point_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid: plane_ready=%b point_ready=%b result_valid=%b counts=%0d/%0d required 1 0 0 0/0",
               plane_ready, point_ready, result_valid, inlier_count, point_count);
    end
    reset = 1'b0;
    tick();
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_signed_normal();
    test_saturation();
    test_back_to_back();
    test_handshake_stress();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
